// File: rtl/im_loader.sv
// Instruction-memory loader: unpacks a framed byte stream (sync, 16-bit count, words, checksum)
// into sequential 16-bit writes, holding the CPU until a load finishes cleanly.
module im_loader #(
  parameter int          ADDR_W    = 11,
  parameter int          DEPTH     = 2048,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]       DEPTH16 = 16'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   count;
  logic [15:0]   idx;
  logic [7:0]    hi_byte;
  logic [7:0]    sum;
  logic [TW-1:0] idle_cnt;
  logic          in_frame;
  logic          timeout_hit;
  logic          arm;
  logic [15:0]   rx_count;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_frame    = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DAT_HI) ||
                  (state == S_DAT_LO) || (state == S_CHK);
    arm         = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    timeout_hit = in_frame && !rx_vld && (idle_cnt == TO_LAST);
    rx_count    = {hi_byte, rx_data};
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_SYNC;
      S_SYNC:   if (rx_vld && rx_data == SYNC_BYTE) state_nxt = S_CNT_HI;
      S_CNT_HI: if (rx_vld) state_nxt = S_CNT_LO;
      S_CNT_LO: if (rx_vld) state_nxt = (rx_count == 16'd0 || rx_count > DEPTH16) ? S_ERR : S_DAT_HI;
      S_DAT_HI: if (rx_vld) state_nxt = S_DAT_LO;
      S_DAT_LO: if (rx_vld) state_nxt = (idx + 16'd1 == count) ? S_CHK : S_DAT_HI;
      S_CHK:    if (rx_vld) state_nxt = (rx_data == sum) ? S_DONE : S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
    if (timeout_hit) state_nxt = S_ERR;
  end

  // Status is a pure function of state; ERR keeps the CPU held until rst or a good load.
  assign busy     = in_frame || (state == S_SYNC);
  assign cpu_hold = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      sum      <= '0;
      idle_cnt <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (!in_frame || rx_vld) idle_cnt <= '0;
      else                     idle_cnt <= idle_cnt + TW'(1);
      if (arm) begin
        idx <= '0;
        sum <= '0;
      end
      if (rx_vld) begin
        case (state)
          S_CNT_HI, S_CNT_LO, S_DAT_HI: sum <= sum + rx_data;
          S_DAT_LO: begin
            sum   <= sum + rx_data;
            we    <= 1'b1;
            waddr <= idx[ADDR_W-1:0];
            wdata <= {hi_byte, rx_data};
            idx   <= idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Byte staging registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (rx_vld) begin
      if (state == S_CNT_HI || state == S_DAT_HI) hi_byte <= rx_data;
      if (state == S_CNT_LO)                      count   <= {hi_byte, rx_data};
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed frames plus random frames checked against a frame-level model.
module tb_im_loader;

  localparam int ADDR_W  = 11;
  localparam int DEPTH   = 2048;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              rx_vld = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              cpu_hold, busy, done, err;

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_vld(rx_vld), .rx_data(rx_data),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0]  frm[$];
  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];
  int          exp_res;   // 0 = still loading, 1 = done, 2 = error

  always @(negedge clk) if (we) got_w.push_back({5'd0, waddr, wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) begin rx_vld = 1'b1; rx_data = b; end
    @(negedge clk) rx_vld = 1'b0;
    idle($urandom_range(0, 3));
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  // Reference: interpret the whole byte list as one frame after a start.
  task automatic model();
    int p;
    logic [15:0] cnt;
    logic [7:0]  s;
    exp_w.delete();
    exp_res = 0;
    p = 0;
    while (p < frm.size() && frm[p] != 8'hA5) p++;
    if (p + 2 >= frm.size()) return;
    cnt = {frm[p+1], frm[p+2]};
    s   = frm[p+1] + frm[p+2];
    p   = p + 3;
    if (cnt == 0 || cnt > DEPTH) begin exp_res = 2; return; end
    for (int w = 0; w < int'(cnt); w++) begin
      if (p + 1 >= frm.size()) return;
      exp_w.push_back({5'd0, 11'(w), frm[p], frm[p+1]});
      s = s + frm[p] + frm[p+1];
      p = p + 2;
    end
    if (p >= frm.size()) return;
    exp_res = (frm[p] == s) ? 1 : 2;
  endtask

  task automatic compare(input string tag);
    idle(3);
    model();
    check({tag, ".nwr"}, got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), got_w[i], exp_w[i]);
    check({tag, ".done"}, done, exp_res == 1);
    check({tag, ".err"}, err, exp_res == 2);
    check({tag, ".busy"}, busy, exp_res == 0);
    check({tag, ".hold"}, cpu_hold, exp_res != 1);
  endtask

  task automatic run_frame(input string tag);
    got_w.delete();
    pulse_start();
    send_frm();
    compare(tag);
  endtask

  initial begin
    idle(3);
    @(negedge clk) rst = 1'b0;
    check("rst.we", we, 0);
    check("rst.waddr", waddr, 0);
    check("rst.wdata", wdata, 0);
    check("rst.flags", {cpu_hold, busy, done, err}, 4'b0000);

    // rx_vld while idle must do nothing
    got_w.delete();
    frm = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h79};
    send_frm();
    idle(3);
    check("idle.nwr", got_w.size(), 0);
    check("idle.flags", {cpu_hold, busy, done, err}, 4'b0000);

    frm = '{8'hA5, 8'h00, 8'h02, 8'hB0, 8'h01, 8'h12, 8'h34, 8'hF9};
    run_frame("good2");
    check("good2.w0", got_w.size() > 0 ? got_w[0] : 32'hX, 32'h0000B001);
    check("good2.w1", got_w.size() > 1 ? got_w[1] : 32'hX, 32'h00011234);
    check("good2.done", done, 1);

    frm = '{8'hA5, 8'h00, 8'h02, 8'hB0, 8'h01, 8'h12, 8'h34, 8'hF8};
    run_frame("badchk");
    check("badchk.err", {err, done, cpu_hold}, 3'b101);

    frm = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h79};
    run_frame("garbage");
    check("garbage.w0", got_w.size() > 0 ? got_w[0] : 32'hX, 32'h0000ABCD);

    frm = '{8'hA5, 8'h00, 8'h00};
    run_frame("cnt0");
    check("cnt0.err", err, 1);
    frm = '{8'hA5, 8'h08, 8'h01, 8'h12, 8'h34};
    run_frame("cnt2049");
    check("cnt2049.err", err, 1);

    // Timeout: stop mid-frame
    got_w.delete();
    pulse_start();
    frm = '{8'hA5, 8'h00, 8'h02, 8'hB0};
    send_frm();
    idle(TIMEOUT - 8);
    check("to.early", {busy, err}, 2'b10);
    idle(12);
    check("to.err", {busy, err, cpu_hold}, 3'b011);
    check("to.nwr", got_w.size(), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("to.rst", {we, waddr, wdata, cpu_hold, busy, done, err}, 32'd0);

    // start pulse inside a frame is ignored
    got_w.delete();
    pulse_start();
    frm = '{8'hA5, 8'h00, 8'h02, 8'hB0};
    send_frm();
    pulse_start();
    send_byte(8'h01);
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hF9);
    frm = '{8'hA5, 8'h00, 8'h02, 8'hB0, 8'h01, 8'h12, 8'h34, 8'hF9};
    compare("midstart");

    // Random frames
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b, s;
      int cnt;
      frm.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        frm.push_back(b);
      end
      cnt = $urandom_range(1, 8);
      frm.push_back(8'hA5);
      frm.push_back(8'h00);
      frm.push_back(8'(cnt));
      s = 8'(cnt);
      for (int k = 0; k < 2 * cnt; k++) begin
        b = 8'($urandom);
        frm.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
      frm.push_back(s);
      run_frame($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
